// File: rtl/rpn_stack_calc.sv
// RPN stack calculator: top of stack in a register, lower entries in a 1W/1R RAM with combinational read.
// Latency: every push/op result is visible on out/cnt right after the executing step edge.
// Backpressure: none; illegal pushes/ops leave state untouched and set the sticky err flag.
module rpn_stack_calc #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             step,
    input  logic             nrst,
    input  logic             push,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    cnt,
    output logic             empty,
    output logic             full,
    output logic             err
);

    // Only entries below the top live in RAM, so DEPTH-1 words suffice.
    localparam int RAM_N = DEPTH - 1;
    localparam int AW    = (RAM_N > 1) ? $clog2(RAM_N) : 1;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_NEG  = 3'd1,
        OP_ADD  = 3'd2,
        OP_MUL  = 3'd3,
        OP_SUB  = 3'd4,
        OP_SWAP = 3'd5,
        OP_DUP  = 3'd6,
        OP_DROP = 3'd7
    } op_e;

    logic [WIDTH-1:0] mem_q [RAM_N];

    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             err_set;
    logic             ram_we;
    logic [AW-1:0]    ram_wa;
    logic [WIDTH-1:0] ram_wd;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] s_val;
    logic             is_empty, is_full, has_two;

    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CW'(DEPTH));
    assign has_two  = (cnt_q >= CW'(2));
    assign rd_addr  = AW'(cnt_q - CW'(2));
    assign s_val    = has_two ? mem_q[rd_addr] : '0;

    always_comb begin
        out_d   = out_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        ram_we  = 1'b0;
        ram_wa  = AW'(cnt_q - CW'(1));
        ram_wd  = out_q;

        if (push) begin
            if (is_full) begin
                err_set = 1'b1;
            end else begin
                ram_we = !is_empty;
                out_d  = d;
                cnt_d  = cnt_q + CW'(1);
            end
        end else begin
            case (op_e'(op))
                OP_NEG: begin
                    if (is_empty) err_set = 1'b1;
                    else          out_d   = -out_q;
                end
                OP_ADD, OP_MUL, OP_SUB: begin
                    if (!has_two) begin
                        err_set = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        if (op_e'(op) == OP_ADD)      out_d = s_val + out_q;
                        else if (op_e'(op) == OP_MUL) out_d = s_val * out_q;
                        else                          out_d = s_val - out_q;
                    end
                end
                OP_SWAP: begin
                    if (!has_two) begin
                        err_set = 1'b1;
                    end else begin
                        out_d  = s_val;
                        ram_we = 1'b1;
                        ram_wa = rd_addr;
                    end
                end
                OP_DUP: begin
                    if (is_full || is_empty) begin
                        err_set = 1'b1;
                    end else begin
                        ram_we = 1'b1;
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
                OP_DROP: begin
                    if (is_empty) begin
                        err_set = 1'b1;
                    end else begin
                        out_d = s_val;
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end

        // A new error outranks a clear on the same edge.
        err_d = err_set | (err_q & ~clr_err);
    end

    always_ff @(posedge step or negedge nrst) begin
        if (!nrst) begin
            out_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // RAM is never reset: nothing below the top is reachable while cnt is 0.
    always_ff @(posedge step) begin
        if (ram_we) mem_q[ram_wa] <= ram_wd;
    end

    assign out   = out_q;
    assign cnt   = cnt_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign err   = err_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed bench for rpn_stack_calc at WIDTH=16, DEPTH=4 with hand-computed expectations.
module tb_rpn_stack_calc;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] NEG  = 3'd1;
    localparam logic [2:0] ADD  = 3'd2;
    localparam logic [2:0] MUL  = 3'd3;
    localparam logic [2:0] SUB  = 3'd4;
    localparam logic [2:0] SWAP = 3'd5;
    localparam logic [2:0] DUP  = 3'd6;
    localparam logic [2:0] DROP = 3'd7;

    logic             step;
    logic             nrst;
    logic             push;
    logic [2:0]       op;
    logic [WIDTH-1:0] d;
    logic             clr_err;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    cnt;
    logic             empty;
    logic             full;
    logic             err;

    int total = 0;
    int bad   = 0;

    rpn_stack_calc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .step    (step),
        .nrst    (nrst),
        .push    (push),
        .op      (op),
        .d       (d),
        .clr_err (clr_err),
        .out     (out),
        .cnt     (cnt),
        .empty   (empty),
        .full    (full),
        .err     (err)
    );

    initial begin
        step = 1'b0;
        forever #5 step = ~step;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [15:0] e_out, input int e_cnt, input logic e_err);
        chk({tag, ".out"}, 32'(out), 32'(e_out));
        chk({tag, ".cnt"}, 32'(cnt), 32'(e_cnt));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
    endtask

    // Drive at the falling edge, let the rising edge execute, sample 1 time unit later.
    task automatic cyc(input logic p, input logic [2:0] o, input logic [15:0] dv, input logic c);
        @(negedge step);
        push = p; op = o; d = dv; clr_err = c;
        @(posedge step);
        #1;
        push = 1'b0; op = NOP; d = '0; clr_err = 1'b0;
    endtask

    task automatic do_push(input logic [15:0] dv);
        cyc(1'b1, NOP, dv, 1'b0);
    endtask

    task automatic do_op(input logic [2:0] o);
        cyc(1'b0, o, 16'h0, 1'b0);
    endtask

    task automatic do_clr();
        cyc(1'b0, NOP, 16'h0, 1'b1);
    endtask

    initial begin
        nrst = 1'b0; push = 1'b0; op = NOP; d = '0; clr_err = 1'b0;
        #12;
        chk_st("reset", 16'h0, 0, 1'b0);
        chk("reset.empty", 32'(empty), 32'd1);
        chk("reset.full", 32'(full), 32'd0);
        @(negedge step);
        nrst = 1'b1;

        // Errors from an empty stack, then clearing.
        do_op(ADD);          chk_st("empty_add", 16'h0, 0, 1'b1);
        do_op(DROP);         chk_st("empty_drop", 16'h0, 0, 1'b1);
        do_clr();            chk_st("clr", 16'h0, 0, 1'b0);
        do_op(NEG);          chk_st("empty_neg", 16'h0, 0, 1'b1);
        do_clr();            chk_st("clr2", 16'h0, 0, 1'b0);
        cyc(1'b1, ADD, 16'd7, 1'b0); chk_st("push_prio", 16'd7, 1, 1'b0);
        do_op(DROP);         chk_st("drop1", 16'h0, 0, 1'b0);

        // Basic arithmetic.
        do_push(16'd3);      chk_st("p3", 16'd3, 1, 1'b0);
        do_push(16'd5);      chk_st("p5", 16'd5, 2, 1'b0);
        do_op(ADD);          chk_st("add", 16'd8, 1, 1'b0);
        do_push(16'd2);      chk_st("p2", 16'd2, 2, 1'b0);
        do_op(MUL);          chk_st("mul", 16'd16, 1, 1'b0);
        do_op(DROP);         chk_st("drop2", 16'h0, 0, 1'b0);

        // Subtract, negate and wrap-around add.
        do_push(16'd10);
        do_push(16'd3);
        do_op(SUB);          chk_st("sub", 16'd7, 1, 1'b0);
        do_op(NEG);          chk_st("neg", 16'hFFF9, 1, 1'b0);
        do_push(16'h0007);   chk_st("p7", 16'h0007, 2, 1'b0);
        do_op(ADD);          chk_st("add_wrap", 16'h0, 1, 1'b0);
        do_op(DROP);         chk_st("drop3", 16'h0, 0, 1'b0);

        // Swap and drop down to empty.
        do_push(16'd1);
        do_push(16'd2);
        do_op(SWAP);         chk_st("swap", 16'd1, 2, 1'b0);
        do_op(DROP);         chk_st("swap_drop", 16'd2, 1, 1'b0);
        do_op(DROP);         chk_st("drop_last", 16'h0, 0, 1'b0);
        chk("drop_last.empty", 32'(empty), 32'd1);

        // Fill to DEPTH, overflow attempts, then unwind through RAM.
        do_push(16'd1);
        do_push(16'd2);
        do_push(16'd3);
        do_push(16'd4);      chk_st("fill", 16'd4, 4, 1'b0);
        chk("fill.full", 32'(full), 32'd1);
        do_push(16'd9);      chk_st("push_full", 16'd4, 4, 1'b1);
        do_op(DUP);          chk_st("dup_full", 16'd4, 4, 1'b1);
        do_clr();            chk_st("clr3", 16'd4, 4, 1'b0);
        do_op(DROP);         chk_st("unwind3", 16'd3, 3, 1'b0);
        chk("unwind3.full", 32'(full), 32'd0);
        do_op(DROP);         chk_st("unwind2", 16'd2, 2, 1'b0);
        do_op(DROP);         chk_st("unwind1", 16'd1, 1, 1'b0);

        // DUP at one entry, set-vs-clear priority, push ignoring op.
        do_op(DUP);          chk_st("dup", 16'd1, 2, 1'b0);
        do_op(ADD);          chk_st("dup_add", 16'd2, 1, 1'b0);
        cyc(1'b0, SWAP, 16'h0, 1'b1); chk_st("set_over_clr", 16'd2, 1, 1'b1);
        do_op(NEG);          chk_st("neg2", 16'hFFFE, 1, 1'b1);
        do_clr();            chk_st("clr4", 16'hFFFE, 1, 1'b0);
        cyc(1'b1, DROP, 16'd5, 1'b0); chk_st("push_ign_op", 16'd5, 2, 1'b0);
        do_op(DROP);         chk_st("drop_ram", 16'hFFFE, 1, 1'b0);
        do_op(DROP);         chk_st("drop4", 16'h0, 0, 1'b0);

        // Truncated multiply, then asynchronous reset between steps.
        do_push(16'h8000);
        do_push(16'h0002);
        do_op(MUL);          chk_st("mul_trunc", 16'h0000, 1, 1'b0);
        do_op(SUB);          chk_st("sub_short", 16'h0000, 1, 1'b1);
        do_push(16'd5);      chk_st("pre_rst", 16'd5, 2, 1'b1);
        nrst = 1'b0;
        #1;
        chk_st("async_rst", 16'h0, 0, 1'b0);
        #1;
        nrst = 1'b1;
        do_push(16'd9);      chk_st("post_rst", 16'd9, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
